// File: rtl/adder_pkg.sv
// Shared definitions for the adder arbiter: widths, slot state and the
// round-robin / overflow helper functions.
package adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  // Widest requester set the pick helper supports.
  localparam int unsigned N_MAX         = 8;

  typedef enum logic {SlotEmpty, SlotFull} slot_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First valid index at or after ptr, searching circularly over n entries.
  function automatic pick_t rr_pick(input logic [N_MAX-1:0] valid,
                                    input logic [2:0]       ptr,
                                    input int               n);
    pick_t p;
    int    j;
    p = '0;
    // Walk from the far end so the nearest hit is the one that remains.
    for (int k = N_MAX - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (k < n && valid[j[2:0]]) begin
        p.found = 1'b1;
        p.idx   = j[2:0];
      end
    end
    return p;
  endfunction

  // Two's-complement overflow: same-sign operands giving a differently signed sum.
  function automatic logic signed_ovf(input logic [WIDTH_DEFAULT-1:0] a,
                                      input logic [WIDTH_DEFAULT-1:0] b,
                                      input logic [WIDTH_DEFAULT-1:0] s);
    return (a[WIDTH_DEFAULT-1] == b[WIDTH_DEFAULT-1]) &&
           (s[WIDTH_DEFAULT-1] != a[WIDTH_DEFAULT-1]);
  endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational adder; carry-out is not exported, the sum wraps.
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  // Modular sum.
  always_comb begin
    o_sum = i_a + i_b;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between N_REQ requesters, with a
// single registered response slot that holds under back-pressure.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_ovf
);

  slot_e            r_slot;
  logic [2:0]       r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;

  logic             w_can_accept;
  logic [N_MAX-1:0] w_valid_ext;
  pick_t            w_pick;
  logic [N_REQ-1:0] w_grant;
  logic             w_xfer;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;

  // Grant generation; only handshake state feeds it, never the operands.
  always_comb begin
    w_can_accept = (r_slot == SlotEmpty) || rsp_ready;
    w_valid_ext  = N_MAX'(req_valid);
    w_pick       = rr_pick(w_valid_ext, r_ptr, int'(N_REQ));
    w_grant      = '0;
    // rst_n gates the grant so nothing is offered while reset is held.
    if (rst_n && w_can_accept && w_pick.found) begin
      w_grant = N_REQ'(1) << w_pick.idx;
    end
    w_xfer = |(req_valid & w_grant);
  end

  // One-hot operand mux in front of the shared adder.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_grant[i]) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  // Result slot, pointer and registered response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= SlotEmpty;
      r_ptr  <= '0;
      r_id   <= '0;
      r_sum  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_xfer) begin
      // Covers simultaneous drain-and-load: the slot simply stays full.
      r_slot <= SlotFull;
      r_sum  <= w_sum;
      r_id   <= ID_W'(w_pick.idx);
      r_ovf  <= signed_ovf(w_a, w_b, w_sum);
      r_ptr  <= (int'(w_pick.idx) == int'(N_REQ) - 1) ? 3'd0 : w_pick.idx + 3'd1;
    end else if (r_slot == SlotFull && rsp_ready) begin
      r_slot <= SlotEmpty;
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = (r_slot == SlotFull);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (3 requesters, 32-bit operands).
module tb_adder_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_ovf;

  int n_vec = 0;
  int n_err = 0;

  adder_arbiter #(
    .N_REQ (N),
    .WIDTH (W),
    .ID_W  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [W-1:0] sum,
                         input logic ovf);
    chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, ".id"},    64'(rsp_id),    64'(id));
    chk({tag, ".sum"},   64'(rsp_sum),   64'(sum));
    chk({tag, ".ovf"},   64'(rsp_ovf),   64'(ovf));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #12;
    // Held reset: nothing granted even with every requester valid.
    chk("rst.ready", 64'(req_ready), 64'd0);
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.id",    64'(rsp_id),    64'd0);
    chk("rst.sum",   64'(rsp_sum),   64'd0);
    chk("rst.ovf",   64'(rsp_ovf),   64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    tick();

    // Single request from requester 0.
    req_valid = 3'b001;
    rsp_ready = 1'b1;
    set_op(0, 32'd5, 32'd7);
    settle();
    chk("single.ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    chk_rsp("single", 2'd0, 32'd12, 1'b0);
    tick();
    chk("single.drain", 64'(rsp_valid), 64'd0);

    // Reset pulse to bring the pointer back to 0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();

    // Round robin with all three valid and the consumer always ready.
    for (int i = 0; i < N; i++) set_op(i, 32'h10 * (i + 1), 32'(i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("rr.grant%0d", k), 64'(req_ready), 64'(1 << (k % 3)));
      if (k > 0) begin
        chk($sformatf("rr.id%0d", k), 64'(rsp_id), 64'((k - 1) % 3));
        chk($sformatf("rr.sum%0d", k), 64'(rsp_sum),
            64'(32'h10 * ((k - 1) % 3 + 1) + (k - 1) % 3));
      end
      tick();
    end
    req_valid = '0;
    chk_rsp("rr.last", 2'd2, 32'h32, 1'b0);
    tick();

    // Back-pressure: load requester 1 (ptr is 0) with a positive overflow case.
    set_op(1, 32'h7FFF_FFFF, 32'h0000_0001);
    req_valid = 3'b010;
    rsp_ready = 1'b0;
    settle();
    chk("bp.fill", 64'(req_ready), 64'b010);
    tick();
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("bp.hold%0d.ready", k), 64'(req_ready), 64'd0);
      chk_rsp($sformatf("bp.hold%0d", k), 2'd1, 32'h8000_0000, 1'b1);
      tick();
    end
    // Drain and accept on the same edge.
    rsp_ready = 1'b1;
    settle();
    chk("bp.pass.ready", 64'(req_ready), 64'b001);
    tick();
    chk_rsp("wrap", 2'd0, 32'h0, 1'b0);
    set_op(0, 32'h8000_0000, 32'h8000_0000);
    settle();
    chk("neg.ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    chk_rsp("negovf", 2'd0, 32'h0, 1'b1);
    tick();

    // Fairness with a gap: ptr is 1, requesters 0 and 2 valid.
    set_op(0, 32'd100, 32'd1);
    set_op(1, 32'd200, 32'd2);
    set_op(2, 32'd300, 32'd3);
    req_valid = 3'b101;
    settle();
    chk("fair.g2", 64'(req_ready), 64'b100);
    tick();
    chk_rsp("fair.r2", 2'd2, 32'd303, 1'b0);
    settle();
    chk("fair.g0", 64'(req_ready), 64'b001);
    tick();
    chk_rsp("fair.r0", 2'd0, 32'd101, 1'b0);
    req_valid = 3'b111;
    settle();
    chk("fair.g1", 64'(req_ready), 64'b010);
    tick();
    chk_rsp("fair.r1", 2'd1, 32'd202, 1'b0);
    settle();
    chk("fair.g2b", 64'(req_ready), 64'b100);
    tick();

    // Asynchronous reset while full and stalled.
    req_valid = '0;
    rsp_ready = 1'b0;
    chk_rsp("ar.full", 2'd2, 32'd303, 1'b0);
    #2;
    rst_n     = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("ar.valid", 64'(rsp_valid), 64'd0);
    chk("ar.ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk("ar.nostale", 64'(rsp_valid), 64'd0);
    req_valid = 3'b111;
    settle();
    chk("ar.ptr0", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    chk_rsp("ar.post", 2'd0, 32'd101, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter sharing one 32-bit ADDER instance between up to N_REQ requesters (PC+4 increment, branch-target, address-offset units) in the MIPS datapath. Each requester presents an operand pair with a valid/ready handshake. The winning pair is added in the accept cycle, and the registered sum is returned on a single response channel tagged with the requester id. The single output register holds under back-pressure, so no result is ever dropped or duplicated.

## Interface
- N_REQ, 3: number of requesters, 2..8.
- WIDTH, 32: operand/sum width; must equal ADDER width (32).
- ID_W, 2: requester-id width, ≥ clog2(N_REQ).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  N_REQ  bit i = requester i presents operands.
- req_a  in  N_REQ*WIDTH  operand A; slice i = bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same slicing.
- req_ready  out  N_REQ  one-hot-or-zero grant; transfer for i when req_valid[i] & req_ready[i].
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer accepts result this cycle.
- rsp_id  out  ID_W  index of requester that produced the result.
- rsp_sum  out  WIDTH  (A + B) mod 2^WIDTH.
- rsp_ovf  out  1  signed overflow of the addition.

## Operation
- Result slot has two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY or (FULL and rsp_ready). This allows pass-through at full throughput.
- Arbitration: when can_accept, grant the first i with req_valid[i]=1, searching circularly from pointer ptr. req_ready = onehot(i). If no request or !can_accept, req_ready = 0.
- req_ready is combinational from req_valid, ptr, rsp_valid and rsp_ready. It never depends on req_a/req_b.
- On transfer for i:
  - rsp_sum ← ADDER(A_i, B_i).
  - rsp_id ← i.
  - rsp_ovf ← (A_i[W-1] == B_i[W-1]) & (sum[W-1] != A_i[W-1]).
  - Slot → FULL.
  - ptr ← (i+1) mod N_REQ.
- FULL and rsp_ready with no transfer → EMPTY. rsp_sum, rsp_id and rsp_ovf keep their last values; they are don't-care while EMPTY.
- FULL and !rsp_ready: all rsp_* outputs stay stable, req_ready = 0.
- ptr advances only on a transfer, so an idle requester never loses its turn.
- Starvation bound: a continuously valid requester is granted within N_REQ transfers.
- Carry-out is discarded; the sum wraps (e.g. 0xFFFFFFFF + 1 = 0x00000000, rsp_ovf=0).

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert at the source):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_ovf=0, ptr=0.
  - req_ready=0 while rst_n=0.
- Latency: transfer at edge T → rsp_valid=1 with the result after edge T, visible in cycle T+1.
- Throughput: one result per cycle when rsp_ready is held high.
- Simultaneous requests: exactly one grant per cycle. The losers keep req_valid high and their operands stable (requester obligation).
- Simultaneous drain and accept: the old result leaves and the new one loads at the same edge. rsp_valid stays 1.
- Reset mid-operation: any FULL result is discarded. No response is issued for it after reset.

## Structure
- Shared package adder_pkg:
  - WIDTH_DEFAULT = 32.
  - Function rr_pick(valid, ptr) returning the grant index and a found flag.
  - Function signed_ovf(a, b, s).
- Exactly one ADDER instance (existing 32-bit combinational adder) fed by the granted operand mux.
- No further sub-module. The arbiter, mux and result register live in adder_arbiter.

## Test plan
- Reset then single request: req_valid=001, A=5, B=7, rsp_ready=1.
  - req_ready=001 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_sum=12, rsp_ovf=0.
- Round-robin, all three valid continuously, rsp_ready=1: grant order 0,1,2,0,1,2, one per cycle, rsp_id following the same order one cycle later.
- Back-pressure: fill the slot, then hold rsp_ready=0 for 4 cycles.
  - req_ready=000 throughout; rsp_* stable.
  - Raise rsp_ready: result drained, and the next grant is accepted on the same edge.
- Wrap and overflow:
  - 0xFFFFFFFF+0x00000001 → sum 0, ovf 0.
  - 0x7FFFFFFF+0x00000001 → 0x80000000, ovf 1.
  - 0x80000000+0x80000000 → 0, ovf 1.
- Fairness with a gap: req 0 and 2 valid, ptr=1 → grant 2, then 0. Requester 1 raised next cycle is granted before 2 again.
- Asynchronous reset while FULL with rsp_ready=0: rsp_valid drops immediately without a clock edge. After release: no stale response, ptr=0.
